// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus: program-memory port, decode-side handshake, redirect, fill level.
// master = fetch stage, slave = memory/decode/branch environment.
interface fetch_queue_stage_if #(
  parameter int A_SIZE = 10,
  parameter int I_SIZE = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [A_SIZE-1:0] pc;
  logic [I_SIZE-1:0] instruction;
  logic              fetch_en;
  logic [I_SIZE-1:0] instr_out;
  logic [A_SIZE-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [A_SIZE-1:0] redirect_addr;
  logic [CW-1:0]     fill_level;

  modport master (
    output pc,
    input  instruction,
    input  fetch_en,
    output instr_out,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect,
    input  redirect_addr,
    output fill_level
  );

  modport slave (
    input  pc,
    output instruction,
    output fetch_en,
    input  instr_out,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect,
    output redirect_addr,
    input  fill_level
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch front end: drives pc, queues {pc,instr} in a show-ahead FIFO.
// Ports: clk, reset (async active-low), bus (fetch_queue_stage_if.master).
module fetch_queue_stage #(
  parameter int A_SIZE = 10,
  parameter int I_SIZE = 16,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic reset,
  fetch_queue_stage_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [A_SIZE-1:0] pc;
    logic [I_SIZE-1:0] ins;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [A_SIZE-1:0] pc_q, pc_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              valid;
  logic              pop;
  logic              push;
  entry_t            head_e;

  assign valid = (cnt_q != '0);
  assign pop   = valid & bus.instr_ready;
  // A full queue may still accept a word when the head leaves this cycle.
  assign push  = bus.fetch_en & ~bus.redirect &
                 ((cnt_q != CW'(DEPTH)) | pop);

  always_comb begin
    mem_d  = mem_q;
    pc_d   = pc_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      bus.redirect: begin
        pc_d   = bus.redirect_addr;
        head_d = '0;
        tail_d = '0;
        cnt_d  = '0;
      end
      default: begin
        if (push) begin
          mem_d[tail_q] = '{pc: pc_q, ins: bus.instruction};
          tail_d = tail_q + 1'b1;
          pc_d   = pc_q + 1'b1;
        end
        if (pop) begin
          head_d = head_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

  // Head is zeroed when empty so stale entries never leak out.
  assign head_e = valid ? mem_q[head_q] : '0;

  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr_out   = head_e.ins;
  assign bus.instr_pc    = head_e.pc;
  assign bus.fill_level  = cnt_q;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: queue model + per-cycle compare + directed literals.
// Program memory is modelled combinationally from bus.pc.
module tb_fetch_queue_stage;
  localparam int A = 10;
  localparam int I = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic started = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [I-1:0] mem [1024];

  fetch_queue_stage_if #(.A_SIZE(A), .I_SIZE(I), .DEPTH(D)) bus ();

  fetch_queue_stage #(.A_SIZE(A), .I_SIZE(I), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.instruction = mem[bus.pc];

  typedef struct {
    logic [A-1:0] pc;
    logic [I-1:0] ins;
  } ent_t;

  ent_t         mq[$];
  logic [A-1:0] m_pc = '0;
  int           m_n;
  logic         m_pop, m_push;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain FIFO of fetched words, pop before push.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pc = '0;
    end else begin
      m_n   = mq.size();
      m_pop = (m_n != 0) && bus.instr_ready;
      if (bus.redirect) begin
        mq.delete();
        m_pc = bus.redirect_addr;
      end else begin
        m_push = bus.fetch_en && ((m_n < D) || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{m_pc, mem[m_pc]});
          m_pc = m_pc + 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("pc", 32'(bus.pc), 32'(m_pc));
      chk("valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
      chk("fill", 32'(bus.fill_level), 32'(mq.size()));
      chk("instr_out", 32'(bus.instr_out),
          mq.size() != 0 ? 32'(mq[0].ins) : 32'd0);
      chk("instr_pc", 32'(bus.instr_pc),
          mq.size() != 0 ? 32'(mq[0].pc) : 32'd0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [I-1:0] lit [4];
  int           wexp [3];
  logic [2:0]   tbl [16];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h5000 + 16'(i);
    mem[0] = 16'h8001;
    mem[1] = 16'h8102;
    mem[2] = 16'h8103;
    mem[3] = 16'h0000;
    lit[0] = 16'h8001;
    lit[1] = 16'h8102;
    lit[2] = 16'h8103;
    lit[3] = 16'h0000;
    bus.fetch_en      = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;

    cyc();
    cyc();
    started = 1'b1;
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_fill", 32'(bus.fill_level), 0);
    chk("rst_iout", 32'(bus.instr_out), 0);
    chk("rst_ipc", 32'(bus.instr_pc), 0);

    reset = 1'b1;
    bus.fetch_en    = 1'b1;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("stream_valid", 32'(bus.instr_valid), 1);
      chk("stream_ipc", 32'(bus.instr_pc), 32'(k));
      chk("stream_iout", 32'(bus.instr_out), 32'(lit[k]));
      chk("stream_fill", 32'(bus.fill_level), 1);
    end

    bus.instr_ready   = 1'b0;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'd0;
    cyc();
    bus.redirect = 1'b0;
    repeat (8) cyc();
    chk("stall_fill", 32'(bus.fill_level), 4);
    chk("stall_pc", 32'(bus.pc), 4);
    chk("stall_ipc", 32'(bus.instr_pc), 0);
    bus.instr_ready = 1'b1;
    cyc();
    chk("fullpop_fill", 32'(bus.fill_level), 4);
    chk("fullpop_pc", 32'(bus.pc), 5);
    chk("fullpop_ipc", 32'(bus.instr_pc), 1);

    bus.fetch_en = 1'b0;
    cyc();
    chk("pre_redir_fill", 32'(bus.fill_level), 3);
    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'd7;
    bus.fetch_en      = 1'b1;
    bus.instr_ready   = 1'b0;
    cyc();
    chk("redir_fill", 32'(bus.fill_level), 0);
    chk("redir_valid", 32'(bus.instr_valid), 0);
    chk("redir_pc", 32'(bus.pc), 7);
    chk("redir_iout", 32'(bus.instr_out), 0);
    bus.redirect = 1'b0;
    cyc();
    chk("tgt_valid", 32'(bus.instr_valid), 1);
    chk("tgt_ipc", 32'(bus.instr_pc), 7);
    chk("tgt_iout", 32'(bus.instr_out), 32'h5007);

    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'd1023;
    bus.instr_ready   = 1'b1;
    cyc();
    chk("wrap_pc", 32'(bus.pc), 1023);
    chk("wrap_valid", 32'(bus.instr_valid), 0);
    bus.redirect = 1'b0;
    wexp[0] = 1023;
    wexp[1] = 0;
    wexp[2] = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("wrap_ipc", 32'(bus.instr_pc), 32'(wexp[k]));
    end

    bus.instr_ready = 1'b0;
    cyc();
    cyc();
    chk("drain_start", 32'(bus.fill_level), 3);
    bus.fetch_en    = 1'b0;
    bus.instr_ready = 1'b1;
    for (int k = 2; k >= 0; k--) begin
      cyc();
      chk("drain_fill", 32'(bus.fill_level), 32'(k));
      chk("drain_pc", 32'(bus.pc), 4);
    end
    chk("drain_valid", 32'(bus.instr_valid), 0);

    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'd20;
    cyc();
    chk("redir_noen_pc", 32'(bus.pc), 20);
    chk("redir_noen_fill", 32'(bus.fill_level), 0);
    bus.redirect = 1'b0;

    bus.fetch_en    = 1'b1;
    bus.instr_ready = 1'b0;
    repeat (5) cyc();
    chk("full_fill", 32'(bus.fill_level), 4);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 0);
    chk("arst_fill", 32'(bus.fill_level), 0);
    chk("arst_pc", 32'(bus.pc), 0);
    chk("arst_iout", 32'(bus.instr_out), 0);
    chk("arst_ipc", 32'(bus.instr_pc), 0);
    cyc();
    reset = 1'b1;

    // {fetch_en, instr_ready, redirect}
    tbl = '{3'b110, 3'b100, 3'b100, 3'b101, 3'b110, 3'b010,
            3'b111, 3'b100, 3'b100, 3'b100, 3'b100, 3'b110,
            3'b011, 3'b110, 3'b000, 3'b010};
    bus.redirect_addr = 10'd1021;
    for (int k = 0; k < 16; k++) begin
      bus.fetch_en    = tbl[k][2];
      bus.instr_ready = tbl[k][1];
      bus.redirect    = tbl[k][0];
      cyc();
    end
    bus.redirect = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the pipeline's decode stage.
- Drives the program-memory address (pc) and captures the 16-bit instruction word returned combinationally in the same cycle.
- Buffers fetched words, each tagged with its address, in a small show-ahead queue.
- Presents the queue head to the pipeline with a valid/ready handshake and supports flush-and-redirect for jumps.

Parameters:
- A_SIZE, 10, program address width; pc wraps modulo 2^A_SIZE.
- I_SIZE, 16, instruction word width.
- DEPTH, 4, queue entries (power of two, >=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc  output  A_SIZE  program-memory address for the current cycle.
- instruction  input  I_SIZE  program-memory data for pc, valid in the same cycle.
- fetch_en  input  1  when 0, no fetch: pc holds, nothing pushed.
- instr_out  output  I_SIZE  queue-head instruction.
- instr_pc  output  A_SIZE  address of instr_out.
- instr_valid  output  1  queue-head valid.
- instr_ready  input  1  consumer accepts the head this cycle.
- redirect  input  1  flush queue and restart fetch at redirect_addr.
- redirect_addr  input  A_SIZE  jump target.
- fill_level  output  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=0, queue empty, fill_level=0, instr_valid=0.
  - instr_out=0 and instr_pc=0; both outputs are forced to 0 whenever the queue is empty.
  - Reset asserted mid-operation discards all entries immediately.
- pop = instr_valid && instr_ready.
- push = fetch_en && !redirect && (fill_level<DEPTH || pop).
- On push:
  - Entry {pc, instruction} is written at the tail.
  - pc <= pc+1, wrapping from 2^A_SIZE-1 to 0.
- Full plus simultaneous pop: push is allowed and fill_level stays DEPTH.
- Empty: no pop is possible; a push makes the entry visible next cycle. Fetch-to-valid latency is 1 edge.
- Show-ahead output:
  - instr_valid = (fill_level!=0).
  - instr_out and instr_pc come from the head entry, combinationally from the storage registers.
- Redirect has highest priority:
  - At the edge: fill_level <= 0, head/tail pointers reset, pc <= redirect_addr.
  - No push occurs that cycle; any pop that cycle is ignored.
  - Cycle after redirect: instr_valid=0, pc=redirect_addr, push occurs if fetch_en.
  - Target instruction is valid 2 edges after redirect was sampled high.
- Redirect while fetch_en=0: pc is still loaded and the queue is still flushed.
- fetch_en=0: pop continues to drain the queue; pc is frozen.
- fill_level = push - pop delta each cycle; it never exceeds DEPTH and never underflows.
- Pointers: log2(DEPTH)-bit circular indices, wrapping naturally.
- Stable head: with instr_valid=1 and instr_ready=0, instr_out and instr_pc hold stable until popped or flushed.

Test Plan:
- Reset release, memory[0..3] = {LOADC R0 1, LOADC R1 2, LOADC R1 3, NOP}, instr_ready=1, fetch_en=1:
  - Cycle 1 after reset: instr_valid=1, instr_pc=0.
  - Following cycles: instr_pc 1,2,3 consecutively.
  - instr_out matches memory; fill_level stays at 1.
- instr_ready=0 for 8 cycles:
  - fill_level reaches 4 after 4 edges; pc stops at 4.
  - instr_pc stays 0.
  - Then instr_ready=1 for one cycle: fill_level stays 4, pc advances to 5, instr_pc becomes 1.
- Redirect to 0x007 while queue holds 3 entries:
  - Next cycle: fill_level=0, instr_valid=0, pc=7.
  - Cycle after: instr_valid=1, instr_pc=7, instr_out=memory[7].
- Wrap-around: redirect_addr=1023, instr_ready=1:
  - Delivered instr_pc sequence is 1023, 0, 1.
- fetch_en=0 with 3 entries, instr_ready=1:
  - Queue drains over 3 cycles, then instr_valid=0.
  - pc unchanged throughout.
- Asynchronous reset asserted mid-cycle with queue full:
  - Immediately: instr_valid=0, fill_level=0, pc=0, instr_out=0, without waiting for a clock edge.
